// File: rtl/uart_fifo_gray_sync_dec.sv
// -----------------------------------------------------------------------------
// uart_fifo_gray_sync_dec
//
// Receive-side companion to the FIFO binary-to-Gray pointer encoder. A Gray
// coded pointer from the opposite clock domain is brought into i_clk through
// a plain flop chain. It is then decoded back to binary and registered. Every
// change of the decoded pointer is reported as a one-cycle update strobe
// together with the modular step size.
//
// Parameters
//   PTR_WIDTH    pointer width in bits (>= 2)
//   SYNC_STAGES  synchroniser depth in flops (>= 2)
//
// Ports
//   i_clk                local clock, rising edge
//   i_rst                synchronous active-high reset
//   i_fifo_dec_gray_ptr  Gray pointer from the foreign domain (asynchronous)
//   o_fifo_dec_bin_ptr   synchronised, decoded binary pointer (registered)
//   o_fifo_dec_gray_ptr  synchronised Gray pointer aligned with the binary one
//   o_fifo_dec_upd       one-cycle pulse when the binary pointer changes
//   o_fifo_dec_delta     (new - old) mod 2^PTR_WIDTH while upd is high, else 0
//   o_fifo_dec_err       one-cycle pulse on an illegal (multi-bit) Gray step
//
// Build option
//   UART_FIFO_GRAY_CHK_EN  when defined, o_fifo_dec_err flags Gray transitions
//                          that flip more than one bit. When undefined,
//                          o_fifo_dec_err is tied to 0 and no checker logic exists.
// -----------------------------------------------------------------------------
module uart_fifo_gray_sync_dec #(
  parameter int PTR_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [PTR_WIDTH-1:0] i_fifo_dec_gray_ptr,
  output logic [PTR_WIDTH-1:0] o_fifo_dec_bin_ptr,
  output logic [PTR_WIDTH-1:0] o_fifo_dec_gray_ptr,
  output logic                 o_fifo_dec_upd,
  output logic [PTR_WIDTH-1:0] o_fifo_dec_delta,
  output logic                 o_fifo_dec_err
);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_WIDTH-1:0] gray_to_bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b            = {PTR_WIDTH{1'b0}};
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

`ifdef UART_FIFO_GRAY_CHK_EN
  // Number of set bits. Used to count how many Gray bits flipped in one step.
  function automatic int unsigned popcount(input logic [PTR_WIDTH-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Synchroniser chain
  // Stage 0 is the only flop that samples the asynchronous input. There is
  // deliberately no logic between stages, so each stage has a full cycle to
  // resolve metastability.
  // ---------------------------------------------------------------------------
  logic [PTR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [PTR_WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [PTR_WIDTH-1:0] gray_s;
  logic [PTR_WIDTH-1:0] bin_s;

  // Next-state of the synchroniser: shift the foreign pointer one stage along.
  always_comb begin
    sync_d[0] = i_fifo_dec_gray_ptr;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Synchroniser flops; reset clears every stage so that Gray 0 (binary 0)
  // comes out of the chain right after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {PTR_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign gray_s = sync_q[SYNC_STAGES-1];
  assign bin_s  = gray_to_bin(gray_s);

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [PTR_WIDTH-1:0] bin_q,   bin_d;
  logic [PTR_WIDTH-1:0] gray_q,  gray_d;
  logic                 upd_q,   upd_d;
  logic [PTR_WIDTH-1:0] delta_q, delta_d;

  // Next-state of the outputs. The step is a plain modular subtraction, so a
  // wrap from all-ones to zero reports a step of 1 and nothing saturates.
  always_comb begin
    gray_d  = gray_s;
    bin_d   = bin_s;
    upd_d   = 1'b0;
    delta_d = {PTR_WIDTH{1'b0}};
    if (bin_s != bin_q) begin
      upd_d   = 1'b1;
      delta_d = bin_s - bin_q;
    end else begin
      upd_d   = 1'b0;
      delta_d = {PTR_WIDTH{1'b0}};
    end
  end

  // Output flops; reset has priority over any pointer activity.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gray_q  <= {PTR_WIDTH{1'b0}};
      bin_q   <= {PTR_WIDTH{1'b0}};
      upd_q   <= 1'b0;
      delta_q <= {PTR_WIDTH{1'b0}};
    end else begin
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      upd_q   <= upd_d;
      delta_q <= delta_d;
    end
  end

  assign o_fifo_dec_gray_ptr = gray_q;
  assign o_fifo_dec_bin_ptr  = bin_q;
  assign o_fifo_dec_upd      = upd_q;
  assign o_fifo_dec_delta    = delta_q;

  // ---------------------------------------------------------------------------
  // Illegal-transition diagnostic
  // A legal Gray step flips at most one bit between consecutive synchronised
  // samples. More than one flipped bit means the producer skipped codes or the
  // chain caught a torn value. Decode still proceeds normally; this is only a flag.
  // ---------------------------------------------------------------------------
`ifdef UART_FIFO_GRAY_CHK_EN
  logic err_q, err_d;

  // Next-state of the error flag: more than one Gray bit changed this cycle.
  always_comb begin
    err_d = 1'b0;
    if (popcount(gray_s ^ gray_q) > 32'd1) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end
  end

  // Error flag flop, aligned with the update strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_fifo_dec_err = err_q;
`else
  assign o_fifo_dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_gray_sync_dec.sv
// -----------------------------------------------------------------------------
// Testbench for uart_fifo_gray_sync_dec (PTR_WIDTH = 4, SYNC_STAGES = 2).
// The reference model works on integers. It keeps in-flight samples in a queue
// and decodes Gray by table search. Expected outputs go into a scoreboard
// queue, and a monitor pops that queue and compares it with the DUT one cycle
// at a time.
// -----------------------------------------------------------------------------
module tb_uart_fifo_gray_sync_dec;

  localparam int W = 4;
  localparam int S = 2;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gin;
  logic [W-1:0] o_bin;
  logic [W-1:0] o_gray;
  logic         o_upd;
  logic [W-1:0] o_delta;
  logic         o_err;

  uart_fifo_gray_sync_dec #(.PTR_WIDTH(W), .SYNC_STAGES(S)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_fifo_dec_gray_ptr (gin),
    .o_fifo_dec_bin_ptr  (o_bin),
    .o_fifo_dec_gray_ptr (o_gray),
    .o_fifo_dec_upd      (o_upd),
    .o_fifo_dec_delta    (o_delta),
    .o_fifo_dec_err      (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int gray;
    int upd;
    int delta;
    int err;
  } exp_t;

  exp_t expq[$];
  int   dq[$];
  int   prev_bin  = 0;
  int   prev_gray = 0;
  bit   model_en  = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  // Decode by searching for the count whose Gray code matches.
  function automatic int dec(input int g);
    for (int n = 0; n < M; n++) begin
      if (((n ^ (n >> 1)) % M) == g) return n;
    end
    return -1;
  endfunction

  function automatic int ones(input int v);
    int c;
    c = 0;
    for (int i = 0; i < W; i++) c += (v >> i) & 1;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: predict the outputs after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    int   g;
    e = '{0, 0, 0, 0, 0};
    if (rst === 1'b1) begin
      dq = {};
      for (int i = 0; i < S; i++) dq.push_back(0);
      prev_bin  = 0;
      prev_gray = 0;
      model_en  = 1'b1;
    end else if (model_en) begin
      g = dq.pop_front();
      dq.push_back(int'(gin));
      e.gray  = g;
      e.bin   = dec(g);
      e.upd   = (e.bin != prev_bin) ? 1 : 0;
      e.delta = e.upd ? ((e.bin - prev_bin + M) % M) : 0;
`ifdef UART_FIFO_GRAY_CHK_EN
      e.err   = (ones(g ^ prev_gray) > 1) ? 1 : 0;
`else
      e.err   = 0;
`endif
      prev_bin  = e.bin;
      prev_gray = g;
    end
    if (model_en) expq.push_back(e);
  end

  // Monitor: compare the DUT against the scoreboard shortly after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() == 0) begin
      if (model_en) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end
    end else begin
      e = expq.pop_front();
      chk("bin",   {28'd0, o_bin},   e.bin);
      chk("gray",  {28'd0, o_gray},  e.gray);
      chk("upd",   {31'd0, o_upd},   e.upd);
      chk("delta", {28'd0, o_delta}, e.delta);
      chk("err",   {31'd0, o_err},   e.err);
    end
  end

  // Apply one input setting at the falling edge and hold it for n cycles.
  task automatic drive(input logic r, input logic [W-1:0] g, input int n);
    @(negedge clk);
    rst = r;
    gin = g;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int           cnt;
    int           r;
    logic         rr;
    logic [W-1:0] gv;
    rst = 1'b1;
    gin = 4'b0110;
    // Reset held with a non-zero input, then released.
    repeat (3) @(negedge clk);
    drive(1'b0, 4'b0110, 6);
    // Counting sequence, one cycle per step.
    drive(1'b0, 4'b0000, 5);
    drive(1'b0, 4'b0001, 1);
    drive(1'b0, 4'b0011, 1);
    drive(1'b0, 4'b0010, 1);
    drive(1'b0, 4'b0110, 5);
    // Wrap from 14 through 15 to 0.
    drive(1'b0, 4'b1001, 5);
    drive(1'b0, 4'b1000, 1);
    drive(1'b0, 4'b0000, 5);
    // Long hold.
    drive(1'b0, 4'b0101, 14);
    // Illegal two-bit jump.
    drive(1'b0, 4'b0000, 5);
    drive(1'b0, 4'b0011, 5);
    // Mid-operation reset with the input held.
    drive(1'b0, 4'b1101, 5);
    drive(1'b1, 4'b1101, 1);
    drive(1'b0, 4'b1101, 6);
    // Random single steps, multi-step jumps, holds and occasional resets.
    cnt = 9;
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 99));
      rr = 1'b0;
      if (r < 50) begin
        cnt = (cnt + 1) % M;
      end else if (r < 60) begin
        cnt = (cnt + int'($urandom_range(2, 5))) % M;
      end else if (r < 62) begin
        rr = 1'b1;
      end
      gv = 4'(cnt ^ (cnt >> 1));
      drive(rr, gv, 1);
    end
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_fifo_gray_sync_dec.md
Name: uart_fifo_gray_sync_dec

Overview:
Receive-side companion to the FIFO binary-to-Gray pointer encoder. It takes a Gray-coded FIFO pointer from the opposite clock domain and synchronises it into the local clock through a flop chain. It then decodes the pointer back to binary and reports each pointer advance: an update strobe plus the modular step size. Used by the UART FIFO full/empty logic on both read and write sides.

Parameters:
PTR_WIDTH, 4, pointer width in bits (Gray and binary); legal values ≥ 2.
SYNC_STAGES, 2, synchroniser depth in flops; legal values ≥ 2.

Ports:
i_clk  input  1  local clock; all flops rising-edge.
i_rst  input  1  reset, synchronous, active-high.
i_fifo_dec_gray_ptr  input  PTR_WIDTH  Gray pointer from the foreign domain; asynchronous to i_clk.
o_fifo_dec_bin_ptr  output  PTR_WIDTH  synchronised, decoded binary pointer (registered).
o_fifo_dec_gray_ptr  output  PTR_WIDTH  synchronised Gray pointer, aligned with o_fifo_dec_bin_ptr (registered).
o_fifo_dec_upd  output  1  one-cycle pulse when o_fifo_dec_bin_ptr changes value.
o_fifo_dec_delta  output  PTR_WIDTH  step size (new − old) mod 2^PTR_WIDTH; valid when o_fifo_dec_upd = 1, otherwise 0.
o_fifo_dec_err  output  1  one-cycle pulse on an illegal Gray transition (only with the optional feature).

Behaviour:
- Reset: i_rst = 1 at a rising edge clears every synchroniser flop and every output to 0. Reset has priority over all other activity, including mid-transfer. Gray 0 decodes to binary 0, so the reset state is self-consistent.
- Synchroniser:
  - sync[0] <= i_fifo_dec_gray_ptr; sync[k] <= sync[k−1]; gray_s = sync[SYNC_STAGES−1].
  - No logic between stages.
- Decode (combinational on gray_s): b[PTR_WIDTH−1] = g[PTR_WIDTH−1]; b[i] = b[i+1] XOR g[i] for i = PTR_WIDTH−2 down to 0.
- Output register, each edge when not in reset:
  - o_fifo_dec_gray_ptr <= gray_s
  - o_fifo_dec_bin_ptr <= dec(gray_s)
  - o_fifo_dec_upd <= (dec(gray_s) != o_fifo_dec_bin_ptr)
  - o_fifo_dec_delta <= upd ? (dec(gray_s) − o_fifo_dec_bin_ptr) truncated to PTR_WIDTH : 0
- Latency: an input that is stable before edge k appears on o_fifo_dec_bin_ptr after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 edges. o_fifo_dec_upd pulses in that same cycle.
- Stable input: o_fifo_dec_upd = 0 and o_fifo_dec_delta = 0 every cycle.
- Wrap-around: all-ones binary to 0 is a normal advance, delta = 1. The subtraction is modular and never saturates.
- Back-to-back changes on consecutive cycles: each produces its own upd pulse with delta 1. No coalescing unless the synchroniser itself skips a value.
- Multi-step jumps caused by slow sampling: delta reports the full step, e.g. 3.
- Reset release with a non-zero input: the first decoded value after SYNC_STAGES+1 edges produces an upd pulse with delta = that value.

Optional Feature:
Macro UART_FIFO_GRAY_CHK_EN.
- Defined:
  - o_fifo_dec_err <= (popcount(gray_s XOR o_fifo_dec_gray_ptr) > 1), registered in the same cycle as upd.
  - Decode and update still proceed normally; err is diagnostic only.
  - err resets to 0.
- Not defined: o_fifo_dec_err is tied to constant 0 and no popcount logic is synthesised.

Test Plan:
(All with PTR_WIDTH = 4, SYNC_STAGES = 2.)
1. Reset: input 0110 with i_rst held 3 cycles -> all outputs 0 throughout. After release, bin = 4 (0100) appears 3 edges later with upd = 1 and delta = 4.
2. Count sequence: Gray 0000→0001→0011→0010→0110, one cycle each -> bin 1, 2, 3, 4 on consecutive cycles, 3 edges after each input change. upd = 1 and delta = 1 each cycle; err = 0.
3. Wrap: from bin 14 (Gray 1001) step to 1000 then 0000 -> bin 15 then 0, delta 1 both times, no err.
4. Hold: input fixed at 0101 (bin 6) for 10 cycles after settling -> upd = 0, delta = 0, bin stays 6.
5. Illegal jump: 0000→0011 -> bin 2, upd = 1, delta = 2. err = 1 for one cycle with UART_FIFO_GRAY_CHK_EN defined; err = 0 without it.
6. Mid-operation reset: i_rst asserted while bin = 9 (Gray 1101) -> next edge all outputs 0. After release with the input still 1101, bin = 9 three edges later, with delta = 9.
